// File: rtl/blur_frame_controller_if.sv
// Avalon-ST beat handshake plus the raw underage classifier flag seen by the blur frame controller.
// The source side drives every field; the controller only observes.
interface blur_frame_controller_if;
    logic valid_in;
    logic ready_in;
    logic startofpacket_in;
    logic endofpacket_in;
    logic underage_req;

    modport master (
        output valid_in,
        output ready_in,
        output startofpacket_in,
        output endofpacket_in,
        output underage_req
    );

    modport slave (
        input valid_in,
        input ready_in,
        input startofpacket_in,
        input endofpacket_in,
        input underage_req
    );
endinterface

// File: rtl/blur_frame_controller.sv
// Frame sequencer for the RGB444 blur filter: tracks pixel position, validates frame geometry and
// turns the per-pixel underage flag into a hysteresis-filtered blur enable that only moves between frames.
module blur_frame_controller #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int KERNEL_W   = 7,
    parameter int KERNEL_H   = 5,
    parameter int ON_FRAMES  = 2,
    parameter int OFF_FRAMES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    blur_frame_controller_if.slave  st,
    output logic                    blur_enable,
    output logic                    window_valid,
    output logic [8:0]              pix_x,
    output logic [7:0]              pix_y,
    output logic [15:0]             frame_count,
    output logic                    frame_error,
    output logic [1:0]              ctrl_state
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam logic [8:0] LAST_X = 9'(IMG_W - 1);
    localparam logic [7:0] LAST_Y = 8'(IMG_H - 1);
    localparam logic [8:0] WIN_X  = 9'(KERNEL_W - 1);
    localparam logic [7:0] WIN_Y  = 8'(KERNEL_H - 1);
    localparam logic [3:0] ON_TH  = 4'(ON_FRAMES);
    localparam logic [3:0] OFF_TH = 4'(OFF_FRAMES);

    state_t      state_q, state_d;
    logic [8:0]  pix_x_d;
    logic [7:0]  pix_y_d;
    logic        acc, sop, eop;
    logic        start_beat, good_eop, err_d;
    logic [8:0]  beat_x;
    logic [7:0]  beat_y;
    logic        underage_q, underage_d, frame_underage;
    logic [3:0]  on_q, off_q, on_d, off_d;
    logic        blur_d;

    assign ctrl_state = state_q;

    always_comb begin
        acc        = st.valid_in && st.ready_in;
        sop        = acc && st.startofpacket_in;
        eop        = acc && st.endofpacket_in;
        state_d    = state_q;
        pix_x_d    = pix_x;
        pix_y_d    = pix_y;
        err_d      = 1'b0;
        good_eop   = 1'b0;
        start_beat = 1'b0;

        case (state_q)
            SYNC: begin
                if (sop) start_beat = 1'b1;
            end
            ACTIVE: begin
                // An SOP mid-frame aborts the current frame and restarts at pixel (0,0)
                if (sop) begin
                    start_beat = 1'b1;
                    err_d      = 1'b1;
                end else if (acc) begin
                    if (pix_x == LAST_X && pix_y == LAST_Y) begin
                        pix_x_d = '0;
                        pix_y_d = '0;
                        if (eop) begin
                            good_eop = 1'b1;
                            state_d  = GAP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = SYNC;
                        end
                    end else if (eop) begin
                        err_d   = 1'b1;
                        state_d = GAP;
                        pix_x_d = '0;
                        pix_y_d = '0;
                    end else if (pix_x == LAST_X) begin
                        pix_x_d = '0;
                        pix_y_d = pix_y + 8'd1;
                    end else begin
                        pix_x_d = pix_x + 9'd1;
                    end
                end
            end
            GAP: begin
                if (sop)      start_beat = 1'b1;
                else if (acc) err_d      = 1'b1;
            end
            default: state_d = SYNC;
        endcase

        if (start_beat) begin
            state_d = ACTIVE;
            pix_x_d = 9'd1;
            pix_y_d = '0;
        end
    end

    // Window qualification uses the position of the beat being consumed, not the next one
    always_comb begin
        beat_x       = (state_q == ACTIVE && !sop) ? pix_x : '0;
        beat_y       = (state_q == ACTIVE && !sop) ? pix_y : '0;
        window_valid = acc && (sop || state_q == ACTIVE) && (beat_y >= WIN_Y) && (beat_x >= WIN_X);
    end

    always_comb begin
        underage_d     = underage_q;
        frame_underage = underage_q || st.underage_req;
        on_d           = on_q;
        off_d          = off_q;
        blur_d         = blur_enable;

        if (start_beat)                         underage_d = st.underage_req;
        else if (acc && state_q == ACTIVE)      underage_d = frame_underage;

        // Streaks and the enable only react to fully validated frames
        if (good_eop) begin
            if (frame_underage) begin
                on_d  = (on_q == 4'hF) ? 4'hF : on_q + 4'd1;
                off_d = '0;
            end else begin
                off_d = (off_q == 4'hF) ? 4'hF : off_q + 4'd1;
                on_d  = '0;
            end
            if (!blur_enable && on_d >= ON_TH)      blur_d = 1'b1;
            else if (blur_enable && off_d >= OFF_TH) blur_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_count <= '0;
            frame_error <= 1'b0;
            blur_enable <= 1'b0;
            underage_q  <= 1'b0;
            on_q        <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            pix_x       <= pix_x_d;
            pix_y       <= pix_y_d;
            frame_error <= err_d;
            blur_enable <= blur_d;
            underage_q  <= underage_d;
            on_q        <= on_d;
            off_q       <= off_d;
            if (good_eop) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_blur_frame_controller.sv
// Self-checking bench for blur_frame_controller on a small 8x4 frame with a 3x2 window:
// table-driven frame vectors through a scoreboard queue, plus hand-written restart/stray/reset sequences.
module tb_blur_frame_controller;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int FRAME = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blur_enable, window_valid, frame_error;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] frame_count;
    logic [1:0]  ctrl_state;

    blur_frame_controller_if sif();

    blur_frame_controller #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL_W(3), .KERNEL_H(2), .ON_FRAMES(2), .OFF_FRAMES(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .st(sif),
        .blur_enable(blur_enable),
        .window_valid(window_valid),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .frame_count(frame_count),
        .frame_error(frame_error),
        .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   n_beats;
        int   uw_idx;
        int   exp_fc;
        logic exp_blur;
        logic exp_err;
        int   exp_state;
        int   exp_wv;
    } vec_t;

    vec_t vecs[14];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wv_count = 0;
    int   blur_glitch = 0;
    logic blur_ref = 1'b0;
    int   err_pulses = 0;

    always @(negedge clk) if (frame_error) err_pulses++;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One beat, with ready flipping every attempt so every other cycle stalls
    task automatic apply_stimulus(input logic sop, input logic eop, input logic uw);
        logic took;
        int   guard;
        took  = 1'b0;
        guard = 0;
        sif.valid_in         = 1'b1;
        sif.startofpacket_in = sop;
        sif.endofpacket_in   = eop;
        sif.underage_req     = uw;
        while (!took && guard < 4) begin
            sif.ready_in = ~sif.ready_in;
            @(negedge clk);
            took = sif.ready_in;
            if (took && window_valid) wv_count++;
            if (blur_enable !== blur_ref) blur_glitch++;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!took) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_accept: got 0, expected 1");
        end
        sif.valid_in         = 1'b0;
        sif.startofpacket_in = 1'b0;
        sif.endofpacket_in   = 1'b0;
        sif.underage_req     = 1'b0;
    endtask

    task automatic send_beats(input logic first_sop, input int n, input int uw_idx, input logic eop_last);
        for (int i = 0; i < n; i++)
            apply_stimulus(first_sop && i == 0, eop_last && i == n - 1, i == uw_idx);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        vec_t e;
        int   e0;

        vecs[0]  = '{FRAME, -1,  1, 1'b0, 1'b0, 2, 18};
        vecs[1]  = '{FRAME, -1,  2, 1'b0, 1'b0, 2, 18};
        vecs[2]  = '{FRAME, -1,  3, 1'b0, 1'b0, 2, 18};
        vecs[3]  = '{FRAME, 12,  4, 1'b0, 1'b0, 2, 18};
        vecs[4]  = '{FRAME, 20,  5, 1'b1, 1'b0, 2, 18};
        vecs[5]  = '{FRAME,  5,  6, 1'b1, 1'b0, 2, 18};
        vecs[6]  = '{FRAME, -1,  7, 1'b1, 1'b0, 2, 18};
        vecs[7]  = '{FRAME,  9,  8, 1'b1, 1'b0, 2, 18};
        vecs[8]  = '{FRAME, -1,  9, 1'b1, 1'b0, 2, 18};
        vecs[9]  = '{FRAME, -1, 10, 1'b1, 1'b0, 2, 18};
        vecs[10] = '{FRAME, -1, 11, 1'b0, 1'b0, 2, 18};
        vecs[11] = '{20,     3, 11, 1'b0, 1'b1, 2,  8};
        vecs[12] = '{FRAME, 31, 12, 1'b0, 1'b0, 2, 18};
        vecs[13] = '{FRAME,  0, 13, 1'b1, 1'b0, 2, 18};

        sif.valid_in         = 1'b0;
        sif.ready_in         = 1'b0;
        sif.startofpacket_in = 1'b0;
        sif.endofpacket_in   = 1'b0;
        sif.underage_req     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_state", ctrl_state, 0);
        check_output("reset_blur", blur_enable, 0);
        check_output("reset_fc", frame_count, 0);
        check_output("reset_pix_x", pix_x, 0);
        check_output("reset_pix_y", pix_y, 0);
        check_output("reset_err", frame_error, 0);
        check_output("reset_wv", window_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        foreach (vecs[i]) begin
            wv_count    = 0;
            blur_glitch = 0;
            blur_ref    = blur_enable;
            e0          = err_pulses;
            exp_q.push_back(vecs[i]);
            send_beats(1'b1, vecs[i].n_beats, vecs[i].uw_idx, 1'b1);
            e = exp_q.pop_front();
            check_output($sformatf("row%0d_fc", i), frame_count, e.exp_fc);
            check_output($sformatf("row%0d_blur", i), blur_enable, e.exp_blur);
            check_output($sformatf("row%0d_err", i), frame_error, e.exp_err);
            check_output($sformatf("row%0d_state", i), ctrl_state, e.exp_state);
            check_output($sformatf("row%0d_blur_stable", i), blur_glitch, 0);
            idle(1);
            check_output($sformatf("row%0d_err_one_cycle", i), frame_error, 0);
            check_output($sformatf("row%0d_err_pulses", i), err_pulses - e0, e.exp_err);
            check_output($sformatf("row%0d_wv", i), wv_count, e.exp_wv);
        end

        send_beats(1'b1, 10, 4, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("restart_err", frame_error, 1);
        check_output("restart_pix_x", pix_x, 1);
        check_output("restart_pix_y", pix_y, 0);
        check_output("restart_state", ctrl_state, 1);
        check_output("restart_fc", frame_count, 13);
        send_beats(1'b0, FRAME - 1, -1, 1'b1);
        check_output("restart_done_fc", frame_count, 14);
        check_output("restart_done_blur", blur_enable, 1);
        check_output("restart_done_state", ctrl_state, 2);

        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("stray_err", frame_error, 1);
        check_output("stray_state", ctrl_state, 2);
        idle(1);
        check_output("stray_err_clear", frame_error, 0);

        send_beats(1'b1, FRAME, -1, 1'b0);
        check_output("no_eop_err", frame_error, 1);
        check_output("no_eop_state", ctrl_state, 0);
        check_output("no_eop_fc", frame_count, 14);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("sync_ignore_state", ctrl_state, 0);
        check_output("sync_ignore_pix_x", pix_x, 0);
        check_output("sync_ignore_err", frame_error, 0);

        send_beats(1'b1, 15, -1, 1'b0);
        check_output("prereset_blur", blur_enable, 1);
        check_output("prereset_pix_x", pix_x, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_blur", blur_enable, 0);
        check_output("async_fc", frame_count, 0);
        check_output("async_state", ctrl_state, 0);
        check_output("async_pix_x", pix_x, 0);
        check_output("async_pix_y", pix_y, 0);
        check_output("async_err", frame_error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        e0 = err_pulses;
        send_beats(1'b0, 5, 2, 1'b0);
        check_output("post_reset_state", ctrl_state, 0);
        check_output("post_reset_pix_x", pix_x, 0);
        send_beats(1'b1, FRAME, -1, 1'b1);
        check_output("post_reset_fc", frame_count, 1);
        check_output("post_reset_blur", blur_enable, 0);
        check_output("post_reset_state_gap", ctrl_state, 2);
        idle(1);
        check_output("post_reset_err_pulses", err_pulses - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
